imm_encoder: RTL and testbench

- Inverse of the immediate generator: packs opcode, register fields, funct3 and a 64-bit signed immediate into one 32-bit instruction word.
- Stores the immediate in the same bit placement that the decode-side immediate generator extracts from.
- Registered, valid/ready streaming stage that also assigns sequential instruction-memory addresses.
- Feeds the instruction-memory loader and the self-check bench; every word it emits round-trips through the immediate generator to the original immediate.

---
 rtl/imm_encoder.sv | 172 +++++++++++++++++
 tb/tb_imm_encoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs opcode, register fields, funct3 and a 64-bit signed immediate into a
// 32-bit instruction word. It is the inverse of the decode-side immediate generator: each
// immediate bit goes to the position the generator reads it back from. This is a
// single-entry registered valid/ready stage. It also numbers emitted words with sequential
// instruction-memory addresses.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   in_valid   request carries valid fields
//   in_ready   stage can accept a request this cycle (!out_valid || out_ready)
//   opcode     instruction[6:0]; opcode[6:5] selects the format (00 I, 01 S, 11 SB, 10 illegal)
//   rd         destination register (I format)
//   rs1        source register 1 (all formats)
//   rs2        source register 2 (S/SB formats)
//   funct3     instruction[14:12]
//   imm        signed immediate; legal range -2048..2047
//   addr_load  load the address counter from addr_base
//   addr_base  new base address
//   out_valid  out_inst/out_addr valid
//   out_ready  consumer accepts the output word
//   out_inst   packed instruction
//   out_addr   address assigned to out_inst
//   err_valid  one-cycle pulse: the last accepted request was rejected
//   err_count  saturating count of rejected requests
module imm_encoder #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [63:0]          imm,
  input  logic                 addr_load,
  input  logic [ADDR_W-1:0]    addr_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 err_valid,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    FmtI   = 2'b00,
    FmtS   = 2'b01,
    FmtBad = 2'b10,
    FmtSb  = 2'b11
  } fmt_e;

  fmt_e fmt;

  logic                 accept;
  logic                 in_range;
  logic                 legal;
  logic [ADDR_W-1:0]    base_addr;
  logic [31:0]          packed_inst;

  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_inst_q, out_inst_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]    next_addr_q, next_addr_d;
  logic                 err_valid_q, err_valid_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  assign fmt = fmt_e'(opcode[6:5]);

  // Skid-free handshake: the single output register frees up in the same cycle it drains.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // imm fits in 12 signed bits iff bits 63..11 are all copies of one value.
  assign in_range = (&imm[63:11]) || !(|imm[63:11]);
  assign legal    = in_range && (fmt != FmtBad);

  // A same-cycle addr_load takes precedence for the accepted word.
  assign base_addr = addr_load ? addr_base : next_addr_q;

  // Field packing. SB immediate is the decoder's raw 12-bit field (already a halfword count),
  // so it is scattered without any shift.
  always_comb begin
    packed_inst        = '0;
    packed_inst[6:0]   = opcode;
    packed_inst[14:12] = funct3;
    packed_inst[19:15] = rs1;
    unique case (fmt)
      FmtI: begin
        packed_inst[31:20] = imm[11:0];
        packed_inst[11:7]  = rd;
      end
      FmtS: begin
        packed_inst[31:25] = imm[11:5];
        packed_inst[24:20] = rs2;
        packed_inst[11:7]  = imm[4:0];
      end
      FmtSb: begin
        packed_inst[31]    = imm[11];
        packed_inst[7]     = imm[10];
        packed_inst[30:25] = imm[9:4];
        packed_inst[11:8]  = imm[3:0];
        packed_inst[24:20] = rs2;
      end
      FmtBad: begin
        // Never emitted; the request is rejected.
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    next_addr_d = base_addr;
    err_valid_d = 1'b0;
    err_count_d = err_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (legal) begin
        // A new word reloads the register even while the old one drains.
        out_valid_d = 1'b1;
        out_inst_d  = packed_inst;
        out_addr_d  = base_addr;
        next_addr_d = base_addr + ADDR_W'(4);
      end else begin
        // Rejected: consumed silently apart from the error report; the address does not advance.
        err_valid_d = 1'b1;
        if (err_count_q != {ERR_CNT_W{1'b1}}) begin
          err_count_d = err_count_q + ERR_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      next_addr_q <= '0;
      err_valid_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      err_valid_q <= err_valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err_valid = err_valid_q;
  assign err_count = err_count_q;

  // A stalled word must stay put until the consumer takes it.
  stall_hold_a: assert property (@(posedge clk) disable iff (!reset)
    out_valid && !out_ready |=> out_valid && $stable(out_inst) && $stable(out_addr));

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [63:0] imm = '0;
  logic        addr_load = 1'b0;
  logic [63:0] addr_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [63:0] out_addr;
  logic        err_valid;
  logic [7:0]  err_count;

  imm_encoder #(.ADDR_W(64), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .imm       (imm),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err_valid (err_valid),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] addr;
    longint      imm;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          err_pulses = 0;
  int          exp_rej = 0;
  logic [63:0] model_next = '0;
  bit          rand_ready = 1'b0;
  bit          ready_force = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint unsigned pow2(input int n);
    return 64'd1 << n;
  endfunction

  // Reference encoder: field values placed by arithmetic weights.
  function automatic logic [31:0] model_inst(input logic [6:0] opc, input logic [4:0] rd_v,
                                             input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                             input logic [2:0] f3, input longint imm_v);
    longint unsigned u, w;
    u = longint'((imm_v + 4096) % 4096);
    w = longint'(opc) + longint'(f3) * pow2(12) + longint'(rs1_v) * pow2(15);
    case (int'(opc) / 32)
      0: w += longint'(rd_v) * pow2(7) + u * pow2(20);
      1: w += (u % 32) * pow2(7) + longint'(rs2_v) * pow2(20) + (u / 32) * pow2(25);
      3: w += (u / 2048) * pow2(31) + ((u / 1024) % 2) * pow2(7) + ((u / 16) % 64) * pow2(25)
              + (u % 16) * pow2(8) + longint'(rs2_v) * pow2(20);
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Decode-side immediate generator, used for the round-trip check.
  function automatic longint decode_imm(input logic [31:0] inst);
    int v;
    case (inst[6:5])
      2'b00:   v = int'(inst[31:20]);
      2'b01:   v = int'({inst[31:25], inst[11:7]});
      default: v = int'({inst[31], inst[7], inst[30:25], inst[11:8]});
    endcase
    if (v >= 2048) v -= 4096;
    return longint'(v);
  endfunction

  task automatic send(input logic [6:0] opc, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                      input logic [4:0] rs2_v, input logic [2:0] f3, input longint imm_v,
                      input bit load, input logic [63:0] base,
                      input bit has_lit, input logic [31:0] lit);
    bit          legal;
    int          waited;
    logic [63:0] a;
    exp_t        e;
    opcode = opc; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; funct3 = f3; imm = 64'(imm_v);
    addr_load = load; addr_base = base; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 1000) break;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0; addr_load = 1'b0;
      return;
    end
    legal = (imm_v >= -2048) && (imm_v <= 2047) && (int'(opc) / 32 != 2);
    a = load ? base : model_next;
    if (legal) begin
      e.inst = has_lit ? lit : model_inst(opc, rd_v, rs1_v, rs2_v, f3, imm_v);
      e.addr = a;
      e.imm  = imm_v;
      sb_q.push_back(e);
      model_next = a + 64'd4;
    end else begin
      model_next = a;
      exp_rej++;
    end
    @(posedge clk);
    #1;
    check("err_valid_after_accept", 64'(err_valid), 64'(!legal));
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  task automatic send_simple(input logic [6:0] opc, input longint imm_v);
    send(opc, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm_v, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; addr_load = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    sb_q.delete();
    model_next = '0; exp_rej = 0; err_pulses = 0;
    #1 reset = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_remaining", 64'(sb_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: handshakes at the next edge are decided by values stable at the negedge.
  bit          held = 1'b0;
  logic [31:0] held_inst;
  logic [63:0] held_addr;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (err_valid) err_pulses++;
      if (held) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_inst", 64'(out_inst), 64'(held_inst));
        check("stall_addr", out_addr, held_addr);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'(out_inst), 64'd0);
          n_fail += (out_inst == 32'd0) ? 1 : 0;
        end else begin
          e = sb_q.pop_front();
          check("out_inst", 64'(out_inst), 64'(e.inst));
          check("out_addr", out_addr, e.addr);
          check("round_trip_imm", 64'(decode_imm(out_inst)), 64'(e.imm));
        end
      end
      held = out_valid && !out_ready;
      held_inst = out_inst;
      held_addr = out_addr;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    reset = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_addr", out_addr, 64'd0);
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed I and S words with known encodings.
    send(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b011, -4, 1'b0, '0, 1'b1, 32'hFFC13283);
    send(7'b0100011, 5'd0, 5'd2, 5'd6, 3'b011, 64'h7FF, 1'b0, '0, 1'b1, 32'h7E613FA3);
    wait_drain();

    // SB streaming with random stalls and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      v = longint'($urandom_range(0, 4095)) - 2048;
      send_simple({2'b11, 5'($urandom)}, v);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    check("stream_no_err", 64'(err_pulses), 64'(exp_rej));

    // Rejects after reset: out of range both sides, then illegal format.
    rand_ready = 1'b0; ready_force = 1'b1;
    do_reset();
    send_simple(7'b0000011, 2048);
    send_simple(7'b0100011, -2049);
    send_simple(7'b1000011, 5);
    @(posedge clk);
    #1;
    check("rej_out_valid", 64'(out_valid), 64'd0);
    check("rej_err_count", 64'(err_count), 64'd3);
    check("rej_err_pulses", 64'(err_pulses), 64'd3);
    send_simple(7'b1100011, 100);
    wait_drain();

    // addr_load alongside a legal accept, then alongside a reject.
    send(7'b0000011, 5'd1, 5'd1, 5'd1, 3'd0, 7, 1'b1, 64'h1000, 1'b0, '0);
    send_simple(7'b0100011, -7);
    send(7'b0000011, 5'd1, 5'd1, 5'd1, 3'd0, 4000, 1'b1, 64'h2000, 1'b0, '0);
    send_simple(7'b1100011, -2048);
    wait_drain();

    // Address wrap.
    send(7'b1100011, 5'd0, 5'd3, 5'd4, 3'd1, 2047, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0);
    send_simple(7'b1100011, 1);
    wait_drain();

    // Saturating reject counter.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: send_simple(7'b0000011, longint'($urandom) + 2048);
        1: send_simple(7'b0100011, -longint'($urandom) - 2049);
        default: send_simple({2'b10, 5'($urandom)}, longint'($urandom_range(0, 100)));
      endcase
    end
    @(posedge clk);
    #1;
    check("sat_err_count", 64'(err_count), 64'(exp_rej > 255 ? 255 : exp_rej));
    check("sat_err_pulses", 64'(err_pulses), 64'(exp_rej));

    // Reset while a word is stalled.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_simple(7'b0000011, -1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_before_reset", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_inst", 64'(out_inst), 64'd0);
    check("midrst_out_addr", out_addr, 64'd0);
    check("midrst_err_count", 64'(err_count), 64'd0);
    sb_q.delete();
    model_next = '0; exp_rej = 0; err_pulses = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ready_force = 1'b1;
    send_simple(7'b0100011, 33);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
